// File: rtl/mc_pkg.sv
// Shared definitions for the microcode sequencer slice.
// Contents: opcode encodings of the control-word ROM, sequencer state type,
// and the step addresses the SHR loop branch jumps to.
package mc_pkg;

  localparam logic [3:0] OP_LDX  = 4'd0;
  localparam logic [3:0] OP_LDY  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  localparam logic [3:0] STEP_LOOP = 4'd2;
  localparam logic [3:0] STEP_HALT = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Opcodes above HALT have no defined action and terminate the run with err.
  function automatic logic is_undef_op(input logic [3:0] op);
    return (op > OP_HALT);
  endfunction

endpackage

// File: rtl/mc_mul_datapath.sv
// X/Y/Z shift-add multiply datapath driven by one-hot enables from the sequencer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_ld_x            X <= zero-extended i_val, Y <= 0, Z <= 0
//   i_ld_y            Y <= i_val
//   i_add             Z <= Z + X when Y[0] is set
//   i_shr             X <= X << 1, Y <= Y >> 1
//   i_val             ROM operand
//   o_z               accumulator
//   o_y_next_zero     Y >> 1 is zero (loop exit condition for the current SHR)
module mc_mul_datapath #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ld_x,
  input  logic              i_ld_y,
  input  logic              i_add,
  input  logic              i_shr,
  input  logic [DATA_W-1:0] i_val,
  output logic [ACC_W-1:0]  o_z,
  output logic              o_y_next_zero
);

  logic [ACC_W-1:0]  r_x;
  logic [DATA_W-1:0] r_y;
  logic [ACC_W-1:0]  r_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
    end else if (i_ld_x) begin
      r_x <= ACC_W'(i_val);
      r_y <= '0;
      r_z <= '0;
    end else if (i_ld_y) begin
      r_y <= i_val;
    end else if (i_add) begin
      if (r_y[0]) r_z <= r_z + r_x;
    end else if (i_shr) begin
      r_x <= r_x << 1;
      r_y <= r_y >> 1;
    end
  end

  assign o_z           = r_z;
  assign o_y_next_zero = ((r_y >> 1) == '0);

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: addresses the combinational control-word ROM with the
// step counter, decodes the returned op into datapath enables, handles the
// SHR loop branch and the start/busy/done/err handshake. Computes Z = X*Y.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      run request, sampled only in IDLE
//   count      ROM step address
//   op_in      ROM opcode for the current step
//   val_in     ROM operand for the current step
//   busy       high while running
//   done       one-cycle pulse when result is valid
//   err        undefined opcode executed; cleared on the next accepted start
//   result     product, updated on halt
module microcode_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [3:0]        count,
  input  logic [3:0]        op_in,
  input  logic [DATA_W-1:0] val_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ACC_W-1:0]  result
);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_count;
  logic             r_err;
  logic [ACC_W-1:0] r_result;

  logic             w_run;
  logic             w_ld_x;
  logic             w_ld_y;
  logic             w_add;
  logic             w_shr;
  logic             w_halt;
  logic             w_undef;
  logic             w_y_next_zero;
  logic [ACC_W-1:0] w_z;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_halt || w_undef) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    w_run   = (r_state == RUN);
    busy    = w_run;
    done    = (r_state == DONE);
    w_ld_x  = w_run && (op_in == OP_LDX);
    w_ld_y  = w_run && (op_in == OP_LDY);
    w_add   = w_run && (op_in == OP_ADD);
    w_shr   = w_run && (op_in == OP_SHR);
    w_halt  = w_run && (op_in == OP_HALT);
    w_undef = w_run && is_undef_op(op_in);
  end

  // Step counter: SHR either re-enters the add/shift loop or falls to halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_run) begin
      if (w_ld_x || w_ld_y || w_add) r_count <= r_count + 4'd1;
      else if (w_shr)                r_count <= w_y_next_zero ? STEP_HALT : STEP_LOOP;
      else                           r_count <= '0;
    end else begin
      r_count <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      if ((r_state == IDLE) && start) r_err <= 1'b0;
      else if (w_undef)               r_err <= 1'b1;
      if (w_halt) r_result <= w_z;
    end
  end

  mc_mul_datapath #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .i_ld_x       (w_ld_x),
    .i_ld_y       (w_ld_y),
    .i_add        (w_add),
    .i_shr        (w_shr),
    .i_val        (val_in),
    .o_z          (w_z),
    .o_y_next_zero(w_y_next_zero)
  );

  assign count  = r_count;
  assign err    = r_err;
  assign result = r_result;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer. A behavioural model turns each
// requested run (X, Y, program kind) into the expected per-cycle output trace;
// a single negedge compare process checks the DUT against it every cycle.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count;
  logic [3:0] op_in;
  logic [3:0] val_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] result;

  always #5 clk = ~clk;

  logic [3:0] rom_op  [16];
  logic [3:0] rom_val [16];
  assign op_in  = rom_op[count];
  assign val_in = rom_val[count];

  microcode_sequencer #(.DATA_W(4), .ACC_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .op_in (op_in),
    .val_in(val_in),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .result(result)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       err;
    logic [7:0] result;
  } exp_t;

  exp_t        q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        m_err = 1'b0;
  logic [7:0]  m_res = 8'd0;
  int          blen = 0;
  int          last_blen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // Compare process: one expected record per cycle, idle expectations otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_err = e.err;
      m_res = e.result;
    end else begin
      e.busy = 1'b0; e.done = 1'b0; e.count = 4'd0;
      e.err = m_err; e.result = m_res;
    end
    chk("busy",   32'(busy),   32'(e.busy));
    chk("done",   32'(done),   32'(e.done));
    chk("count",  32'(count),  32'(e.count));
    chk("err",    32'(err),    32'(e.err));
    chk("result", 32'(result), 32'(e.result));
    if (rst) blen = 0;
    else if (busy) blen++;
    else if (done) begin last_blen = blen; blen = 0; end
  end

  function automatic int bitlen(input int v);
    int n = 0;
    while (v != 0) begin n++; v = v >> 1; end
    return n;
  endfunction

  task automatic set_prog(input logic [3:0] x, input logic [3:0] y, input bit bad);
    for (int i = 0; i < 16; i++) begin rom_op[i] = 4'hF; rom_val[i] = 4'h0; end
    rom_op[0] = 4'd0; rom_val[0] = x;
    rom_op[1] = 4'd1; rom_val[1] = y;
    rom_op[2] = bad ? 4'b0111 : 4'd2;
    rom_op[3] = 4'd3;
    rom_op[4] = 4'd4;
  endtask

  function automatic exp_t mk(input logic b, input logic d, input int c, input logic e, input logic [7:0] r);
    exp_t t;
    t.busy = b; t.done = d; t.count = 4'(c); t.err = e; t.result = r;
    return t;
  endfunction

  // Model of one run: idle sampling cycle, RUN step trace, DONE cycle.
  task automatic push_run(input int x, input int y, input bit bad, input int max_run,
                          inout logic cur_err, inout logic [7:0] cur_res);
    int n;
    int k;
    int trace[$];
    q.push_back(mk(1'b0, 1'b0, 0, cur_err, cur_res));
    if (bad) trace = '{0, 1, 2};
    else begin
      trace = '{0, 1};
      n = (bitlen(y) > 1) ? bitlen(y) : 1;
      for (int i = 0; i < n; i++) begin trace.push_back(2); trace.push_back(3); end
      trace.push_back(4);
    end
    k = 0;
    foreach (trace[i]) begin
      if (k < max_run) q.push_back(mk(1'b1, 1'b0, trace[i], 1'b0, cur_res));
      k++;
    end
    if (max_run < trace.size()) return;
    if (bad) cur_err = 1'b1;
    else begin cur_err = 1'b0; cur_res = 8'((x * y) % 256); end
    q.push_back(mk(1'b0, 1'b1, 0, cur_err, cur_res));
  endtask

  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 200) begin @(posedge clk); i++; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d records left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input int x, input int y, input bit bad, input int reps);
    logic       ce;
    logic [7:0] cr;
    set_prog(4'(x), 4'(y), bad);
    @(posedge clk); #1;
    ce = m_err; cr = m_res;
    for (int r = 0; r < reps; r++) push_run(x, y, bad, 99, ce, cr);
    start = 1'b1;
    if (reps == 1) begin @(posedge clk); #1; start = 1'b0; end
    drain();
    #1 start = 1'b0;
  endtask

  task automatic run_reset_mid();
    logic       ce;
    logic [7:0] cr;
    set_prog(4'd4, 4'd4, 1'b0);
    @(posedge clk); #1;
    ce = m_err; cr = m_res;
    push_run(4, 4, 1'b0, 2, ce, cr);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    drain();
    #2 rst = 1'b1;
    m_res = 8'd0; m_err = 1'b0;
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_count",  32'(count),  32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done",   32'(done),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    set_prog(4'd0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run(4, 4, 1'b0, 1);
    chk("pin_res_4x4", 32'(result), 32'd16);
    chk("pin_len_4x4", 32'(last_blen), 32'd9);

    run(15, 15, 1'b0, 1);
    chk("pin_res_15x15", 32'(result), 32'd225);
    chk("pin_len_15x15", 32'(last_blen), 32'd11);

    run(7, 6, 1'b1, 1);
    chk("pin_err_set", 32'(err), 32'd1);
    chk("pin_err_keep_res", 32'(result), 32'd225);

    run(9, 0, 1'b0, 1);
    chk("pin_res_y0", 32'(result), 32'd0);
    chk("pin_len_y0", 32'(last_blen), 32'd5);
    chk("pin_err_clr", 32'(err), 32'd0);

    run(3, 5, 1'b0, 1);
    chk("pin_res_3x5", 32'(result), 32'd15);
    run(6, 2, 1'b0, 2);
    chk("pin_res_held", 32'(result), 32'd12);

    run_reset_mid();

    for (int i = 0; i < 25; i++) begin
      int x = int'($urandom_range(0, 15));
      int y = int'($urandom_range(0, 15));
      bit b = ($urandom_range(0, 7) == 0);
      int r = int'($urandom_range(1, 2));
      run(x, y, b, r);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
